// File: rtl/word_checker.sv
// word_checker: scores the three-slot letter buffer against a fixed 3-letter target word.
//
// On a rising edge of submit while idle, letter1..letter3 are captured and scored. The result
// is one of pass, fail or incomplete, held for RESULT_HOLD cycles. A match latches solved and
// parks the block in a terminal state. MAX_ATTEMPTS failures lock the block out.
//
// Optional feature (macro WORD_CHECKER_LOCKOUT_TIMER_EN):
//   Defined   : lockout lasts LOCKOUT_CYCLES cycles, then attempts clears and the block
//               returns to idle.
//   Undefined : lockout is terminal until rst, and no lockout counter exists.
//
// Ports:
//   clk                      system clock
//   rst                      asynchronous, active-high reset
//   submit                   debounced button level; only rising edges act
//   letter1..letter3 [5:0]   slot codes, 0..25 = a..z, 6'h3F = blank
//   busy                     high in every state except idle
//   pass / fail / incomplete result flags, high only during the result window
//   attempts [3:0]           scored (pass or fail) submissions, saturating at 15
//   locked                   high while locked out
//   solved                   sticky once the word has been matched
module word_checker #(
  parameter logic [5:0]  TARGET1        = 6'd2,
  parameter logic [5:0]  TARGET2        = 6'd0,
  parameter logic [5:0]  TARGET3        = 6'd19,
  parameter int unsigned MAX_ATTEMPTS   = 5,
  parameter int unsigned RESULT_HOLD    = 50000000,
  parameter int unsigned LOCKOUT_CYCLES = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       submit,
  input  logic [5:0] letter1,
  input  logic [5:0] letter2,
  input  logic [5:0] letter3,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic       incomplete,
  output logic [3:0] attempts,
  output logic       locked,
  output logic       solved
);

  typedef enum logic [2:0] {StIdle, StCheck, StResult, StSolved, StLocked} state_e;

  localparam logic [3:0]  MaxAttempts = 4'(MAX_ATTEMPTS);
  localparam logic [31:0] HoldLoad    = 32'(RESULT_HOLD - 1);

  state_e      r_state, w_state_d;
  logic        r_submit;
  logic [5:0]  r_l1, r_l2, r_l3, w_l1_d, w_l2_d, w_l3_d;
  logic [31:0] r_hold, w_hold_d;
  logic        r_pass, r_fail, r_incomplete, w_pass_d, w_fail_d, w_incomplete_d;
  logic [3:0]  r_attempts, w_attempts_d, w_attempts_inc;
  logic        r_solved, w_solved_d;
  logic        w_press, w_bad, w_match;

`ifdef WORD_CHECKER_LOCKOUT_TIMER_EN
  localparam logic [31:0] LockLoad = 32'(LOCKOUT_CYCLES - 1);
  logic [31:0] r_lock_cnt, w_lock_cnt_d;
`else
  logic w_unused_lockout;
  assign w_unused_lockout = ^LOCKOUT_CYCLES;
`endif

  assign w_press        = submit & ~r_submit;
  assign w_bad          = (r_l1 > 6'd25) | (r_l2 > 6'd25) | (r_l3 > 6'd25);
  assign w_match        = (r_l1 == TARGET1) & (r_l2 == TARGET2) & (r_l3 == TARGET3);
  assign w_attempts_inc = (r_attempts == 4'd15) ? r_attempts : r_attempts + 4'd1;

  always_comb begin
    w_state_d      = r_state;
    w_l1_d         = r_l1;
    w_l2_d         = r_l2;
    w_l3_d         = r_l3;
    w_hold_d       = r_hold;
    w_pass_d       = r_pass;
    w_fail_d       = r_fail;
    w_incomplete_d = r_incomplete;
    w_attempts_d   = r_attempts;
    w_solved_d     = r_solved;
`ifdef WORD_CHECKER_LOCKOUT_TIMER_EN
    w_lock_cnt_d   = r_lock_cnt;
`endif
    case (r_state)
      StIdle: begin
        if (w_press) begin
          w_l1_d    = letter1;
          w_l2_d    = letter2;
          w_l3_d    = letter3;
          w_state_d = StCheck;
        end
      end
      StCheck: begin
        w_hold_d  = HoldLoad;
        w_state_d = StResult;
        if (w_bad) begin
          w_incomplete_d = 1'b1;
        end else if (w_match) begin
          w_pass_d     = 1'b1;
          w_solved_d   = 1'b1;
          w_attempts_d = w_attempts_inc;
        end else begin
          w_fail_d     = 1'b1;
          w_attempts_d = w_attempts_inc;
        end
      end
      StResult: begin
        if (r_hold == 32'd0) begin
          w_pass_d       = 1'b0;
          w_fail_d       = 1'b0;
          w_incomplete_d = 1'b0;
          if (r_pass) begin
            w_state_d = StSolved;
          end else if (r_fail && (r_attempts == MaxAttempts)) begin
            w_state_d = StLocked;
`ifdef WORD_CHECKER_LOCKOUT_TIMER_EN
            w_lock_cnt_d = LockLoad;
`endif
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_hold_d = r_hold - 32'd1;
        end
      end
      StSolved: begin
        w_state_d = StSolved;
      end
      StLocked: begin
`ifdef WORD_CHECKER_LOCKOUT_TIMER_EN
        if (r_lock_cnt == 32'd0) begin
          w_state_d    = StIdle;
          w_attempts_d = 4'd0;
        end else begin
          w_lock_cnt_d = r_lock_cnt - 32'd1;
        end
`else
        w_state_d = StLocked;
`endif
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      // Reset high so a button held through reset is not seen as a press.
      r_submit     <= 1'b1;
      r_l1         <= 6'd0;
      r_l2         <= 6'd0;
      r_l3         <= 6'd0;
      r_hold       <= 32'd0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_incomplete <= 1'b0;
      r_attempts   <= 4'd0;
      r_solved     <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_submit     <= submit;
      r_l1         <= w_l1_d;
      r_l2         <= w_l2_d;
      r_l3         <= w_l3_d;
      r_hold       <= w_hold_d;
      r_pass       <= w_pass_d;
      r_fail       <= w_fail_d;
      r_incomplete <= w_incomplete_d;
      r_attempts   <= w_attempts_d;
      r_solved     <= w_solved_d;
    end
  end

`ifdef WORD_CHECKER_LOCKOUT_TIMER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock_cnt <= 32'd0;
    end else begin
      r_lock_cnt <= w_lock_cnt_d;
    end
  end
`endif

  assign busy       = (r_state != StIdle);
  assign locked     = (r_state == StLocked);
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign incomplete = r_incomplete;
  assign attempts   = r_attempts;
  assign solved     = r_solved;

endmodule

// File: tb/tb_word_checker.sv
module tb_word_checker;

  localparam int unsigned HOLD = 4;
  localparam int unsigned LOCK = 10;
  localparam int unsigned MAXA = 3;
  localparam logic [5:0]  T1   = 6'd2;
  localparam logic [5:0]  T2   = 6'd0;
  localparam logic [5:0]  T3   = 6'd19;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       submit = 1'b0;
  logic [5:0] letter1 = 6'd0;
  logic [5:0] letter2 = 6'd0;
  logic [5:0] letter3 = 6'd0;
  logic       busy, pass, fail, incomplete, locked, solved;
  logic [3:0] attempts;

  word_checker #(
    .TARGET1       (T1),
    .TARGET2       (T2),
    .TARGET3       (T3),
    .MAX_ATTEMPTS  (MAXA),
    .RESULT_HOLD   (HOLD),
    .LOCKOUT_CYCLES(LOCK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .submit    (submit),
    .letter1   (letter1),
    .letter2   (letter2),
    .letter3   (letter3),
    .busy      (busy),
    .pass      (pass),
    .fail      (fail),
    .incomplete(incomplete),
    .attempts  (attempts),
    .locked    (locked),
    .solved    (solved)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: what the user has achieved so far.
  int m_attempts = 0;
  bit m_solved   = 1'b0;

  // Samples taken by run_press: index 0 is just after the press edge, 1..4 the result window,
  // 5 the first cycle after the window.
  logic [2:0] obs_flags [0:5];
  logic       obs_busy  [0:5];
  logic       obs_lock  [0:5];
  logic       obs_solv  [0:5];
  logic [3:0] obs_att   [0:5];

  // 0 = incomplete, 1 = pass, 2 = fail
  function automatic int classify(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    if (a > 6'd25 || b > 6'd25 || c > 6'd25) return 0;
    if (a == T1 && b == T2 && c == T3) return 1;
    return 2;
  endfunction

  // {pass, fail, incomplete}
  function automatic logic [2:0] flags_of(input int cls);
    if (cls == 1) return 3'b100;
    if (cls == 2) return 3'b010;
    return 3'b001;
  endfunction

  function automatic void model_score(input int cls);
    if (cls != 0) m_attempts = (m_attempts >= 15) ? 15 : m_attempts + 1;
    if (cls == 1) m_solved = 1'b1;
  endfunction

  task automatic rand_fail_word(output logic [5:0] a, output logic [5:0] b, output logic [5:0] c);
    do begin
      a = 6'($urandom_range(0, 25));
      b = 6'($urandom_range(0, 25));
      c = 6'($urandom_range(0, 25));
    end while (classify(a, b, c) != 2);
  endtask

  task automatic sample(input int i);
    obs_flags[i] = {pass, fail, incomplete};
    obs_busy[i]  = busy;
    obs_lock[i]  = locked;
    obs_solv[i]  = solved;
    obs_att[i]   = attempts;
  endtask

  // Stimulus only: press with the given word, optionally change letter3 right after the
  // capture edge and/or pulse submit again inside the result window.
  task automatic run_press(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                           input bit mutate, input bit repress);
    @(negedge clk);
    letter1 = a; letter2 = b; letter3 = c; submit = 1'b1;
    @(negedge clk);
    sample(0);
    submit = 1'b0;
    if (mutate) letter3 = 6'((int'(T3) + 1 + int'($urandom_range(0, 20))) % 26);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      sample(i);
      if (repress && i == 1) submit = 1'b1;
      if (repress && i == 2) submit = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; submit = 1'b1;
    letter1 = T1; letter2 = T2; letter3 = T3;
    @(negedge clk);
    checks++;
    if ({busy, pass, fail, incomplete, locked, solved, attempts} !== 10'd0) begin
      errors++;
      $display("FAIL reset_values: got busy=%b p=%b f=%b i=%b lk=%b s=%b att=%0d want all 0",
               busy, pass, fail, incomplete, locked, solved, attempts);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, pass, fail, incomplete} !== 4'b0000) begin
        errors++;
        $display("FAIL held_submit_no_eval[%0d]: got busy=%b flags=%b want 0 000",
                 i, busy, {pass, fail, incomplete});
      end
    end
    submit = 1'b0;
    @(negedge clk);
    m_attempts = 0;
    m_solved   = 1'b0;
  endtask

  task automatic test_reset_mid_window;
    logic [5:0] a, b, c;
    rand_fail_word(a, b, c);
    @(negedge clk);
    letter1 = a; letter2 = b; letter3 = c; submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    @(negedge clk);
    model_score(classify(a, b, c));
    checks++;
    if (fail !== 1'b1 || attempts !== 4'(m_attempts)) begin
      errors++;
      $display("FAIL pre_reset_fail: got fail=%b att=%0d want 1 %0d", fail, attempts, m_attempts);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, pass, fail, incomplete, locked, solved, attempts} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b p=%b f=%b i=%b lk=%b s=%b att=%0d want all 0",
               busy, pass, fail, incomplete, locked, solved, attempts);
    end
    @(negedge clk);
    rst = 1'b0;
    m_attempts = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL after_async_reset: got busy=%b fail=%b want 0 0", busy, fail);
    end
  endtask

  task automatic test_incomplete;
    logic [5:0] w [0:2];
    int cls;
    for (int n = 0; n < 3; n++) begin
      for (int s = 0; s < 3; s++) w[s] = 6'($urandom_range(0, 25));
      w[$urandom_range(0, 2)] = (n == 0) ? 6'h3F : 6'($urandom_range(26, 63));
      cls = classify(w[0], w[1], w[2]);
      run_press(w[0], w[1], w[2], 1'b0, 1'b0);
      model_score(cls);
      checks++;
      if (obs_busy[0] !== 1'b1 || obs_flags[0] !== 3'b000) begin
        errors++;
        $display("FAIL inc_check_cycle: got busy=%b flags=%b want 1 000", obs_busy[0], obs_flags[0]);
      end
      for (int i = 1; i <= 4; i++) begin
        checks++;
        if (obs_flags[i] !== flags_of(cls)) begin
          errors++;
          $display("FAIL inc_window[%0d]: got %b want %b", i, obs_flags[i], flags_of(cls));
        end
      end
      checks++;
      if (obs_att[1] !== 4'(m_attempts)) begin
        errors++;
        $display("FAIL inc_attempts: got %0d want %0d", obs_att[1], m_attempts);
      end
      checks++;
      if (obs_flags[5] !== 3'b000 || obs_busy[5] !== 1'b0) begin
        errors++;
        $display("FAIL inc_exit: got flags=%b busy=%b want 000 0", obs_flags[5], obs_busy[5]);
      end
    end
  endtask

  task automatic test_fail_lockout;
    logic [5:0] a, b, c;
    bit exp_lock;
    for (int n = 1; n <= int'(MAXA); n++) begin
      rand_fail_word(a, b, c);
      run_press(a, b, c, 1'b0, 1'b0);
      model_score(classify(a, b, c));
      for (int i = 1; i <= 4; i++) begin
        checks++;
        if (obs_flags[i] !== 3'b010) begin
          errors++;
          $display("FAIL fail_window[%0d] try %0d: got %b want 010", i, n, obs_flags[i]);
        end
      end
      checks++;
      if (obs_att[1] !== 4'(m_attempts)) begin
        errors++;
        $display("FAIL fail_attempts try %0d: got %0d want %0d", n, obs_att[1], m_attempts);
      end
      exp_lock = (m_attempts == int'(MAXA));
      checks++;
      if (obs_flags[5] !== 3'b000 || obs_lock[5] !== exp_lock || obs_busy[5] !== exp_lock) begin
        errors++;
        $display("FAIL fail_exit try %0d: got flags=%b locked=%b busy=%b want 000 %b %b",
                 n, obs_flags[5], obs_lock[5], obs_busy[5], exp_lock, exp_lock);
      end
    end
`ifdef WORD_CHECKER_LOCKOUT_TIMER_EN
    for (int i = 1; i < int'(LOCK); i++) begin
      @(negedge clk);
      checks++;
      if (locked !== 1'b1) begin
        errors++;
        $display("FAIL lock_hold[%0d]: got locked=%b want 1", i, locked);
      end
    end
    @(negedge clk);
    m_attempts = 0;
    checks++;
    if (locked !== 1'b0 || busy !== 1'b0 || attempts !== 4'd0) begin
      errors++;
      $display("FAIL lock_expire: got locked=%b busy=%b att=%0d want 0 0 0", locked, busy, attempts);
    end
    rand_fail_word(a, b, c);
    run_press(a, b, c, 1'b0, 1'b0);
    model_score(classify(a, b, c));
    checks++;
    if (obs_flags[1] !== 3'b010 || obs_att[1] !== 4'(m_attempts)) begin
      errors++;
      $display("FAIL post_lock_press: got flags=%b att=%0d want 010 %0d",
               obs_flags[1], obs_att[1], m_attempts);
    end
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 50) submit = 1'b1;
      if (i == 52) submit = 1'b0;
      checks++;
      if (locked !== 1'b1 || busy !== 1'b1 || attempts !== 4'(m_attempts) ||
          {pass, fail, incomplete} !== 3'b000) begin
        errors++;
        $display("FAIL lock_terminal[%0d]: got locked=%b busy=%b att=%0d flags=%b want 1 1 %0d 000",
                 i, locked, busy, attempts, {pass, fail, incomplete}, m_attempts);
      end
    end
`endif
  endtask

  task automatic test_match_capture;
    int cls;
    cls = classify(T1, T2, T3);
    run_press(T1, T2, T3, 1'b1, 1'b1);
    model_score(cls);
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (obs_flags[i] !== flags_of(cls) || obs_att[i] !== 4'(m_attempts)) begin
        errors++;
        $display("FAIL match_window[%0d]: got flags=%b att=%0d want %b %0d",
                 i, obs_flags[i], obs_att[i], flags_of(cls), m_attempts);
      end
    end
    checks++;
    if (obs_solv[1] !== m_solved) begin
      errors++;
      $display("FAIL match_solved: got %b want %b", obs_solv[1], m_solved);
    end
    checks++;
    if (obs_flags[5] !== 3'b000 || obs_busy[5] !== 1'b1 || obs_lock[5] !== 1'b0) begin
      errors++;
      $display("FAIL match_exit: got flags=%b busy=%b locked=%b want 000 1 0",
               obs_flags[5], obs_busy[5], obs_lock[5]);
    end
  endtask

  task automatic test_back_to_back;
    // A fresh press once solved must be ignored.
    @(negedge clk);
    submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({pass, fail, incomplete} !== 3'b000 || busy !== 1'b1 || solved !== 1'b1 ||
          attempts !== 4'(m_attempts)) begin
        errors++;
        $display("FAIL solved_ignores_press[%0d]: got flags=%b busy=%b s=%b att=%0d want 000 1 1 %0d",
                 i, {pass, fail, incomplete}, busy, solved, attempts, m_attempts);
      end
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_window;
    test_incomplete;
    test_fail_lockout;
    test_reset;
    test_match_capture;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
